redmule_tcdm_splitter: RTL and testbench
========================================

REDMULE_TCDM_SPLITTER -- requirements
Module: redmule_tcdm_splitter

Interface
REQ-001: Parameter DW, default redmule_pkg DATA_W; width of the wide (streamer-side) data bus in bits; multiple of 32.
REQ-002: Parameter MP, default DW/32; number of independent 32-bit TCDM lanes.
REQ-003: clk_i  in  1  single clock; all state on rising edge.
REQ-004: rst_ni  in  1  reset, asynchronous, active-low.
REQ-005: wide_req_i  in  1  wide request; upstream holds it and the payload stable until wide_gnt_o.
REQ-006: wide_gnt_o  out  1  wide grant; all lanes accepted.
REQ-007: wide_add_i  in  32  byte address of lane 0.
REQ-008: wide_wen_i  in  1  1=read, 0=write.
REQ-009: wide_be_i  in  DW/8  byte enables.
REQ-010: wide_data_i  in  DW  write data.
REQ-011: wide_r_data_o  out  DW  read data; lane i in bits [32i+31:32i].
REQ-012: wide_r_valid_o  out  1  one-cycle pulse; full wide response available.
REQ-013: tcdm_req_o  out  MP  per-lane request.
REQ-014: tcdm_gnt_i  in  MP  per-lane grant.
REQ-015: tcdm_add_o  out  MP x 32  per-lane address.
REQ-016: tcdm_wen_o  out  MP  per-lane wen (copy of wide_wen_i).
REQ-017: tcdm_be_o  out  MP x 4  lane i = wide_be_i[4i+3:4i].
REQ-018: tcdm_data_o  out  MP x 32  lane i = wide_data_i[32i+31:32i].
REQ-019: tcdm_r_data_i  in  MP x 32  per-lane response data.
REQ-020: tcdm_r_valid_i  in  MP  per-lane response valid (reads and writes).

Function
REQ-021: FSM states IDLE, ISSUE, WAIT_RSP; at most one wide transaction outstanding.
REQ-022: tcdm_add_o[i] = wide_add_i + 4*i, modulo 2^32.
REQ-023: tcdm_req_o[i] = wide_req_i AND state in {IDLE, ISSUE} AND NOT issued[i]; 0 in WAIT_RSP.
REQ-024: issued[i] is set on tcdm_req_o[i] AND tcdm_gnt_i[i]; a granted lane never re-requests within the same transaction.
REQ-025: wide_gnt_o is combinational: high when state in {IDLE, ISSUE}, wide_req_i=1 and every lane is either issued or granted this cycle.
REQ-026: IDLE -> ISSUE on wide_req_i with a partial grant; IDLE/ISSUE -> WAIT_RSP on wide_gnt_o; issued mask cleared on wide_gnt_o.
REQ-027: rsp_mask[i] and data buffer lane i captured on tcdm_r_valid_i[i] in any state, including ISSUE (early lanes respond before late lanes are granted).
REQ-028: tcdm_r_valid_i[i] with rsp_mask[i] already set is ignored (data not overwritten); a simulation assertion flags it.
REQ-029: When rsp_mask OR tcdm_r_valid_i is all ones in WAIT_RSP: wide_r_valid_o registered high for exactly the next cycle with the complete buffer on wide_r_data_o; rsp_mask cleared; state -> IDLE.
REQ-030: Latency: wide_r_valid_o rises one cycle after the last lane response arrives.
REQ-031: wide_r_data_o holds last response until the next capture; only wide_r_valid_o qualifies it.
REQ-032: wide_req_i held high after wide_gnt_o: no lane request until state returns to IDLE (cycle after wide_r_valid_o is registered).
REQ-033: wide_req_i dropping in ISSUE is a protocol violation; lanes drop req, issued mask retained, assertion flags it.

Reset
REQ-034: On rst_ni=0 (any state, including mid-transaction): state IDLE; issued, rsp_mask, data buffer cleared; wide_r_valid_o=0, wide_r_data_o=0; tcdm_req_o=0 while in reset.
REQ-035: Responses in flight at reset are not recovered; first post-reset request behaves as from power-up.

Verification (MP=4, DW=128)
REQ-036: Read, add=0x1000, all gnt=1 same cycle -> tcdm_add_o 0x1000/0x1004/0x1008/0x100C, wide_gnt_o same cycle; r_valid all next cycle with 0xA0..0xA3 -> wide_r_valid_o one cycle later, r_data=0x000000A3_000000A2_000000A1_000000A0.
REQ-037: Lane 2 gnt delayed 3 cycles -> lanes 0,1,3 req drop after grant, lane 2 held; single wide_gnt_o in lane-2 grant cycle.
REQ-038: Responses staggered lane 3,0,1,2 over 4 cycles, including lane 0 during ISSUE -> one wide_r_valid_o pulse one cycle after lane 2, data correct.
REQ-039: add=0xFFFFFFF8 -> lane addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-040: Reset asserted in WAIT_RSP with two lanes responded -> outputs zero; next write of be=0xFFFF completes with single wide_r_valid_o.
REQ-041: wide_req_i held across two transactions -> no tcdm_req_o between wide_gnt_o and the cycle after wide_r_valid_o; exactly two gnt and two r_valid pulses.

Source files
------------

// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide streamer transaction into MP independent 32-bit TCDM lane
// transactions and merges the lane responses back into a single wide response.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wide_*               streamer side: req/gnt handshake, address of lane 0,
//                        wen (1=read), byte enables, write data, and the merged
//                        read data with a one-cycle valid pulse
//   tcdm_*               per-lane TCDM side: req/gnt, address, wen, be, wdata,
//                        response data and response valid
//
// At most one wide transaction is outstanding. Lanes may be granted in
// different cycles; a granted lane is masked until the whole wide request is
// accepted. Lane responses are buffered as they arrive (even before the last
// lane is granted), and the wide response fires one cycle after the last one.
module redmule_tcdm_splitter #(
    parameter int unsigned DW = 128,  // redmule_pkg DATA_W
    parameter int unsigned MP = DW / 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // Wide (streamer) side
    input  logic                  wide_req_i,
    output logic                  wide_gnt_o,
    input  logic [31:0]           wide_add_i,
    input  logic                  wide_wen_i,
    input  logic [DW/8-1:0]       wide_be_i,
    input  logic [DW-1:0]         wide_data_i,
    output logic [DW-1:0]         wide_r_data_o,
    output logic                  wide_r_valid_o,
    // Narrow (TCDM) side
    output logic [MP-1:0]         tcdm_req_o,
    input  logic [MP-1:0]         tcdm_gnt_i,
    output logic [MP-1:0][31:0]   tcdm_add_o,
    output logic [MP-1:0]         tcdm_wen_o,
    output logic [MP-1:0][3:0]    tcdm_be_o,
    output logic [MP-1:0][31:0]   tcdm_data_o,
    input  logic [MP-1:0][31:0]   tcdm_r_data_i,
    input  logic [MP-1:0]         tcdm_r_valid_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

    state_e              state_q, state_d;
    logic [MP-1:0]       issued_q, issued_d;
    logic [MP-1:0]       rsp_mask_q, rsp_mask_d;
    logic [MP-1:0][31:0] rdata_q, rdata_d;
    logic                r_valid_q, r_valid_d;

    logic                issuing;
    logic [MP-1:0]       lane_gnt;
    logic [MP-1:0]       new_rsp;
    logic                rsp_done;

    // Static per-lane payload slicing and address generation (wraps mod 2^32).
    for (genvar i = 0; i < MP; i++) begin : g_lane
        assign tcdm_add_o[i]  = wide_add_i + 32'(4 * i);
        assign tcdm_be_o[i]   = wide_be_i[4*i +: 4];
        assign tcdm_data_o[i] = wide_data_i[32*i +: 32];
    end
    assign tcdm_wen_o = {MP{wide_wen_i}};

    assign issuing  = (state_q == StIdle) || (state_q == StIssue);
    assign lane_gnt = tcdm_req_o & tcdm_gnt_i;
    // Duplicate responses for an already-captured lane are dropped.
    assign new_rsp  = tcdm_r_valid_i & ~rsp_mask_q;
    assign rsp_done = (state_q == StWaitRsp) && (&(rsp_mask_q | tcdm_r_valid_i));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            issued_q   <= '0;
            rsp_mask_q <= '0;
            rdata_q    <= '0;
            r_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            rsp_mask_q <= rsp_mask_d;
            rdata_q    <= rdata_d;
            r_valid_q  <= r_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q | lane_gnt;
        rsp_mask_d = rsp_mask_q | new_rsp;
        rdata_d    = rdata_q;
        r_valid_d  = 1'b0;

        for (int i = 0; i < MP; i++) begin
            if (new_rsp[i]) rdata_d[i] = tcdm_r_data_i[i];
        end

        unique case (state_q)
            StIdle: begin
                if (wide_gnt_o)                   state_d = StWaitRsp;
                else if (wide_req_i && |lane_gnt) state_d = StIssue;
            end
            StIssue: begin
                if (wide_gnt_o) state_d = StWaitRsp;
            end
            StWaitRsp: begin
                if (rsp_done) begin
                    state_d    = StIdle;
                    rsp_mask_d = '0;
                    r_valid_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wide_gnt_o) issued_d = '0;
    end

    // Outputs; lane requests are forced low while reset is asserted.
    always_comb begin
        tcdm_req_o = '0;
        wide_gnt_o = 1'b0;
        if (rst_ni && wide_req_i && issuing) begin
            tcdm_req_o = ~issued_q;
            wide_gnt_o = &(issued_q | (~issued_q & tcdm_gnt_i));
        end
    end

    assign wide_r_valid_o = r_valid_q;
    assign wide_r_data_o  = rdata_q;

`ifndef SYNTHESIS
    a_no_dup_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (tcdm_r_valid_i & rsp_mask_q) == '0)
        else $error("lane response received twice in one transaction");

    a_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StIssue) |-> wide_req_i)
        else $error("wide_req_i dropped before wide grant");
`endif

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
module tb_redmule_tcdm_splitter;

    localparam int unsigned DW = 128;
    localparam int unsigned MP = 4;

    logic                clk;
    logic                rst_n;
    logic                wide_req;
    logic                wide_gnt;
    logic [31:0]         wide_add;
    logic                wide_wen;
    logic [DW/8-1:0]     wide_be;
    logic [DW-1:0]       wide_data;
    logic [DW-1:0]       wide_r_data;
    logic                wide_r_valid;
    logic [MP-1:0]       tcdm_req;
    logic [MP-1:0]       tcdm_gnt;
    logic [MP-1:0][31:0] tcdm_add;
    logic [MP-1:0]       tcdm_wen;
    logic [MP-1:0][3:0]  tcdm_be;
    logic [MP-1:0][31:0] tcdm_data;
    logic [MP-1:0][31:0] tcdm_r_data;
    logic [MP-1:0]       tcdm_r_valid;

    int checks = 0;
    int errors = 0;
    int gnt_cnt = 0;
    int rv_cnt = 0;
    logic [DW-1:0] exp_q[$];

    redmule_tcdm_splitter #(.DW(DW), .MP(MP)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wide_req_i     (wide_req),
        .wide_gnt_o     (wide_gnt),
        .wide_add_i     (wide_add),
        .wide_wen_i     (wide_wen),
        .wide_be_i      (wide_be),
        .wide_data_i    (wide_data),
        .wide_r_data_o  (wide_r_data),
        .wide_r_valid_o (wide_r_valid),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every wide response pulse pops one expected value.
    always @(negedge clk) begin
        if (rst_n && wide_gnt) gnt_cnt++;
        if (rst_n && wide_r_valid) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got r_valid with data %h expected no response",
                         wide_r_data);
            end else begin
                chk("sb_rdata", wide_r_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g0;
        int r0;
        rst_n = 1'b0; wide_req = 1'b1; wide_add = '0; wide_wen = 1'b1;
        wide_be = '0; wide_data = '0; tcdm_gnt = '0; tcdm_r_data = '0; tcdm_r_valid = '0;

        // Reset state, with wide_req high to prove lane requests are gated.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", wide_r_valid, 0);
        chk("rst_rdata", wide_r_data, 0);
        chk("rst_req", tcdm_req, 0);
        chk("rst_gnt", wide_gnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; wide_req = 1'b0;
        step();

        // Read, all lanes granted in the same cycle.
        wide_req = 1'b1; wide_add = 32'h1000; wide_wen = 1'b1; wide_be = 16'hF0A5;
        tcdm_gnt = 4'hF;
        @(negedge clk);
        chk("t1_add0", tcdm_add[0], 32'h1000);
        chk("t1_add1", tcdm_add[1], 32'h1004);
        chk("t1_add2", tcdm_add[2], 32'h1008);
        chk("t1_add3", tcdm_add[3], 32'h100C);
        chk("t1_req", tcdm_req, 4'hF);
        chk("t1_gnt", wide_gnt, 1);
        chk("t1_wen", tcdm_wen, 4'hF);
        chk("t1_be", tcdm_be, 16'hF0A5);
        exp_q.push_back(128'h000000A3_000000A2_000000A1_000000A0);
        step();
        wide_req = 1'b0; tcdm_gnt = '0; tcdm_r_valid = 4'hF;
        tcdm_r_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        @(negedge clk);
        chk("t1_wait_req", tcdm_req, 0);
        chk("t1_rv_early", wide_r_valid, 0);
        step();
        tcdm_r_valid = '0; tcdm_r_data = {4{32'hDEADBEEF}};
        @(negedge clk);
        chk("t1_rv", wide_r_valid, 1);
        step();
        @(negedge clk);
        chk("t1_rv_pulse", wide_r_valid, 0);
        chk("t1_rdata_hold", wide_r_data, 128'h000000A3_000000A2_000000A1_000000A0);
        step();

        // Lane 2 grant delayed; staggered responses 3,0,1,2 with lane 0 in ISSUE.
        g0 = gnt_cnt;
        wide_req = 1'b1; wide_add = 32'h2000; tcdm_gnt = 4'b1011;
        @(negedge clk);
        chk("t2_c0_req", tcdm_req, 4'hF);
        chk("t2_c0_gnt", wide_gnt, 0);
        step();
        tcdm_gnt = 4'b0000; tcdm_r_valid = 4'b1000;
        tcdm_r_data = {32'hB3, 32'h11111111, 32'h22222222, 32'h33333333};
        @(negedge clk);
        chk("t2_c1_req", tcdm_req, 4'b0100);
        chk("t2_c1_gnt", wide_gnt, 0);
        step();
        tcdm_r_valid = 4'b0001;
        tcdm_r_data = {32'h44444444, 32'h55555555, 32'h66666666, 32'hB0};
        @(negedge clk);
        chk("t2_c2_req", tcdm_req, 4'b0100);
        step();
        tcdm_r_valid = '0; tcdm_gnt = 4'b0100;
        @(negedge clk);
        chk("t2_c3_req", tcdm_req, 4'b0100);
        chk("t2_c3_gnt", wide_gnt, 1);
        exp_q.push_back(128'h000000B3_000000B2_000000B1_000000B0);
        step();
        wide_req = 1'b0; tcdm_gnt = '0; tcdm_r_valid = 4'b0010;
        tcdm_r_data = {32'h77777777, 32'h88888888, 32'hB1, 32'h99999999};
        @(negedge clk);
        chk("t2_c4_req", tcdm_req, 0);
        step();
        tcdm_r_valid = 4'b0100;
        tcdm_r_data = {32'hAAAAAAAA, 32'hB2, 32'hCCCCCCCC, 32'hDDDDDDDD};
        @(negedge clk);
        chk("t2_c5_rv", wide_r_valid, 0);
        step();
        tcdm_r_valid = '0;
        @(negedge clk);
        chk("t2_c6_rv", wide_r_valid, 1);
        chk("t2_gnt_pulses", gnt_cnt - g0, 1);
        step();

        // Address wrap-around; no grant so nothing is issued.
        wide_req = 1'b1; wide_add = 32'hFFFFFFF8;
        @(negedge clk);
        chk("t3_add0", tcdm_add[0], 32'hFFFFFFF8);
        chk("t3_add1", tcdm_add[1], 32'hFFFFFFFC);
        chk("t3_add2", tcdm_add[2], 32'h00000000);
        chk("t3_add3", tcdm_add[3], 32'h00000004);
        step();
        wide_req = 1'b0;
        step();

        // Reset in WAIT_RSP with lanes 0,1 responded, then a full write.
        wide_req = 1'b1; wide_add = 32'h3000; wide_wen = 1'b1; tcdm_gnt = 4'hF;
        step();
        wide_req = 1'b0; tcdm_gnt = '0; tcdm_r_valid = 4'b0011;
        tcdm_r_data = {32'h0, 32'h0, 32'hC1, 32'hC0};
        step();
        tcdm_r_valid = '0; rst_n = 1'b0; wide_req = 1'b1;
        @(negedge clk);
        chk("t4_rst_rv", wide_r_valid, 0);
        chk("t4_rst_rdata", wide_r_data, 0);
        chk("t4_rst_req", tcdm_req, 0);
        step();
        rst_n = 1'b1; wide_req = 1'b0;
        step();
        wide_req = 1'b1; wide_add = 32'h4000; wide_wen = 1'b0; wide_be = 16'hFFFF;
        wide_data = 128'h44444444_33333333_22222222_11111111; tcdm_gnt = 4'hF;
        @(negedge clk);
        chk("t4_wdata", tcdm_data, 128'h44444444_33333333_22222222_11111111);
        chk("t4_be", tcdm_be, 16'hFFFF);
        chk("t4_wen", tcdm_wen, 4'h0);
        chk("t4_gnt", wide_gnt, 1);
        exp_q.push_back(128'h000000D3_000000D2_000000D1_000000D0);
        step();
        wide_req = 1'b0; tcdm_gnt = '0; tcdm_r_valid = 4'hF;
        tcdm_r_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        step();
        tcdm_r_valid = '0;
        @(negedge clk);
        chk("t4_rv", wide_r_valid, 1);
        step();

        // wide_req held across two back-to-back transactions.
        g0 = gnt_cnt; r0 = rv_cnt;
        wide_req = 1'b1; wide_add = 32'h5000; wide_wen = 1'b1; tcdm_gnt = 4'hF;
        @(negedge clk);
        chk("t5_c0_gnt", wide_gnt, 1);
        exp_q.push_back(128'h000000E3_000000E2_000000E1_000000E0);
        step();
        tcdm_r_valid = 4'hF; tcdm_r_data = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        @(negedge clk);
        chk("t5_c1_req", tcdm_req, 0);
        chk("t5_c1_gnt", wide_gnt, 0);
        step();
        tcdm_r_valid = '0; wide_add = 32'h6000;
        @(negedge clk);
        chk("t5_c2_rv", wide_r_valid, 1);
        chk("t5_c2_req", tcdm_req, 4'hF);
        chk("t5_c2_gnt", wide_gnt, 1);
        exp_q.push_back(128'h000000F3_000000F2_000000F1_000000F0);
        step();
        tcdm_r_valid = 4'hF; tcdm_r_data = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        @(negedge clk);
        chk("t5_c3_req", tcdm_req, 0);
        step();
        tcdm_r_valid = '0; wide_req = 1'b0; tcdm_gnt = '0;
        @(negedge clk);
        chk("t5_c4_rv", wide_r_valid, 1);
        step();
        @(negedge clk);
        chk("t5_gnt_pulses", gnt_cnt - g0, 2);
        chk("t5_rv_pulses", rv_cnt - r0, 2);
        step();

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
